// File: rtl/hmsg_rr_arbiter.sv
// rtl/hmsg_rr_arbiter.sv - four-to-one req/ack message merger with debounced handshakes
// Define HMSG_ARB_FIXED_PRIO_EN for fixed priority (0 highest); default is round-robin.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 2
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 2
`endif
`ifndef NS_REQ_CKS
`define NS_REQ_CKS 2
`endif

module hmsg_rr_arbiter #(
    parameter int ASZ = `NS_ADDRESS_SIZE,
    parameter int DSZ = `NS_DATA_SIZE,
    parameter int RSZ = `NS_REDUN_SIZE,
    parameter int REQ_CKS = `NS_REQ_CKS,
    localparam int MSZ = ASZ + DSZ + RSZ
) (
    input  logic           gch_clk,
    input  logic           gch_reset,
    output logic           gch_ready,
    input  logic           rcv0_req,
    input  logic [MSZ-1:0] rcv0_data,
    output logic           rcv0_ack_out,
    input  logic           rcv1_req,
    input  logic [MSZ-1:0] rcv1_data,
    output logic           rcv1_ack_out,
    input  logic           rcv2_req,
    input  logic [MSZ-1:0] rcv2_data,
    output logic           rcv2_ack_out,
    input  logic           rcv3_req,
    input  logic [MSZ-1:0] rcv3_data,
    output logic           rcv3_ack_out,
    output logic           snd0_req_out,
    output logic [MSZ-1:0] snd0_data_out,
    input  logic           snd0_ack
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WAIT_ACK,
        S_WAIT_REL,
        S_WAIT_DONE
    } state_t;

    localparam int CW = (REQ_CKS < 2) ? 1 : $clog2(REQ_CKS + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(REQ_CKS - 1);
    localparam logic [CW-1:0] CNT_PRIME = CW'(REQ_CKS);

    // Bits 0..3 are the producer requests, bit 4 is the consumer ack.
    logic [4:0]     raw;
    logic [4:0]     filt;
    logic [CW-1:0]  cnt [5];
    logic [CW-1:0]  prime_cnt;
    logic           primed;

    logic [MSZ-1:0] rcv_data [4];

    state_t         state, state_nxt;
    logic [1:0]     ptr, ptr_nxt;
    logic [1:0]     gnt, gnt_nxt;
    logic           rg_rdy, rdy_nxt;
    logic           req_nxt;
    logic [3:0]     ack_q, ack_nxt;
    logic [MSZ-1:0] data_nxt;

    logic           found;
    logic [1:0]     sel;
    logic [1:0]     idx;

    assign raw = {snd0_ack, rcv3_req, rcv2_req, rcv1_req, rcv0_req};
    assign rcv_data[0] = rcv0_data;
    assign rcv_data[1] = rcv1_data;
    assign rcv_data[2] = rcv2_data;
    assign rcv_data[3] = rcv3_data;

    always_ff @(posedge gch_clk or posedge gch_reset) begin
        if (gch_reset) begin
            filt      <= '0;
            prime_cnt <= '0;
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
        end else begin
            if (prime_cnt != CNT_PRIME) prime_cnt <= prime_cnt + CW'(1);
            for (int i = 0; i < 5; i++) begin
                if (raw[i] != filt[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        filt[i] <= raw[i];
                        cnt[i]  <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign primed    = (prime_cnt == CNT_PRIME);
    assign gch_ready = rg_rdy & primed;

    // First filtered request at or after the pointer, wrapping modulo four.
    always_comb begin
        found = 1'b0;
        sel   = ptr;
        idx   = '0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && filt[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_ff @(posedge gch_clk or posedge gch_reset) begin
        if (gch_reset) begin
            state         <= S_INIT;
            ptr           <= '0;
            gnt           <= '0;
            rg_rdy        <= 1'b0;
            snd0_req_out  <= 1'b0;
            ack_q         <= '0;
            snd0_data_out <= '0;
        end else begin
            state         <= state_nxt;
            ptr           <= ptr_nxt;
            gnt           <= gnt_nxt;
            rg_rdy        <= rdy_nxt;
            snd0_req_out  <= req_nxt;
            ack_q         <= ack_nxt;
            snd0_data_out <= data_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gnt_nxt   = gnt;
        rdy_nxt   = rg_rdy;
        req_nxt   = snd0_req_out;
        ack_nxt   = ack_q;
        data_nxt  = snd0_data_out;
        case (state)
            S_INIT: begin
                rdy_nxt   = 1'b1;
                state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (gch_ready && found) begin
                    gnt_nxt   = sel;
                    data_nxt  = rcv_data[sel];
                    req_nxt   = 1'b1;
                    state_nxt = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (filt[4]) begin
                    ack_nxt[gnt] = 1'b1;
                    state_nxt    = S_WAIT_REL;
                end
            end
            S_WAIT_REL: begin
                if (!filt[gnt]) begin
                    ack_nxt[gnt] = 1'b0;
                    req_nxt      = 1'b0;
                    state_nxt    = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!filt[4]) begin
`ifdef HMSG_ARB_FIXED_PRIO_EN
                    ptr_nxt = 2'd0;
`else
                    ptr_nxt = gnt + 2'd1;
`endif
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_INIT;
        endcase
    end

    assign rcv0_ack_out = ack_q[0];
    assign rcv1_ack_out = ack_q[1];
    assign rcv2_ack_out = ack_q[2];
    assign rcv3_ack_out = ack_q[3];

endmodule

// File: tb/tb_hmsg_rr_arbiter.sv
// tb/tb_hmsg_rr_arbiter.sv - self-checking bench for hmsg_rr_arbiter
module tb_hmsg_rr_arbiter;

    localparam int ASZ = 2, DSZ = 8, RSZ = 2, REQ_CKS = 2;
    localparam int MSZ = ASZ + DSZ + RSZ;
    localparam int P_INIT = 0, P_IDLE = 1, P_ACK = 2, P_REL = 3, P_DONE = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           gch_ready;
    logic [3:0]     req_v;
    logic [MSZ-1:0] data_v [4];
    logic           ack0, ack1, ack2, ack3;
    logic [3:0]     ack_v;
    logic           snd0_req_out;
    logic [MSZ-1:0] snd0_data_out;
    logic           snd0_ack;

    logic [3:0]     want;
    logic [3:0]     prev_ack;
    int             d_grants[$];
    int             m_grants[$];
    int             n_vec = 0;
    int             n_bad = 0;

    // Reference model state
    int             m_state, m_ptr, m_g, m_since;
    bit [4:0]       m_filt;
    bit [4:0]       m_hist [REQ_CKS];
    bit             m_req;
    bit [3:0]       m_ack;
    logic [MSZ-1:0] m_data;

    always #5 clk = ~clk;
    assign ack_v = {ack3, ack2, ack1, ack0};

    hmsg_rr_arbiter #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ), .REQ_CKS(REQ_CKS)) dut (
        .gch_clk(clk), .gch_reset(rst), .gch_ready(gch_ready),
        .rcv0_req(req_v[0]), .rcv0_data(data_v[0]), .rcv0_ack_out(ack0),
        .rcv1_req(req_v[1]), .rcv1_data(data_v[1]), .rcv1_ack_out(ack1),
        .rcv2_req(req_v[2]), .rcv2_data(data_v[2]), .rcv2_ack_out(ack2),
        .rcv3_req(req_v[3]), .rcv3_data(data_v[3]), .rcv3_ack_out(ack3),
        .snd0_req_out(snd0_req_out), .snd0_data_out(snd0_data_out), .snd0_ack(snd0_ack)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return m_since >= ((REQ_CKS > 1) ? REQ_CKS : 1);
    endfunction

    task automatic model_reset();
        m_state = P_INIT; m_ptr = 0; m_g = 0; m_since = 0;
        m_filt = '0; m_req = 0; m_ack = '0; m_data = '0;
        for (int s = 0; s < REQ_CKS; s++) m_hist[s] = '0;
    endtask

    // One rising edge of the specified behaviour, using pre-edge filtered levels.
    task automatic model_step();
        bit [4:0] raw;
        bit       diff;
        int       best, bd;
        if (rst) begin
            model_reset();
            return;
        end
        raw = {snd0_ack, req_v};
        case (m_state)
            P_INIT: m_state = P_IDLE;
            P_IDLE: if (m_ready()) begin
                best = -1; bd = 4;
                for (int c = 0; c < 4; c++)
                    if (m_filt[c] && ((c - m_ptr + 4) % 4) < bd) begin
                        bd = (c - m_ptr + 4) % 4;
                        best = c;
                    end
                if (best >= 0) begin
                    m_g = best; m_data = data_v[best]; m_req = 1;
                    m_state = P_ACK; m_grants.push_back(best);
                end
            end
            P_ACK: if (m_filt[4]) begin m_ack[m_g] = 1; m_state = P_REL; end
            P_REL: if (!m_filt[m_g]) begin m_ack[m_g] = 0; m_req = 0; m_state = P_DONE; end
            P_DONE: if (!m_filt[4]) begin
`ifdef HMSG_ARB_FIXED_PRIO_EN
                m_ptr = 0;
`else
                m_ptr = (m_g + 1) % 4;
`endif
                m_state = P_IDLE;
            end
            default: m_state = P_INIT;
        endcase
        for (int s = REQ_CKS - 1; s > 0; s--) m_hist[s] = m_hist[s-1];
        m_hist[0] = raw;
        for (int k = 0; k < 5; k++) begin
            diff = 1;
            for (int s = 0; s < REQ_CKS; s++) if (m_hist[s][k] == m_filt[k]) diff = 0;
            if (diff) m_filt[k] = raw[k];
        end
        if (m_since < 1000) m_since++;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("snd0_req_out", snd0_req_out, m_req);
        chk("rcv_ack_out", ack_v, m_ack);
        chk("gch_ready", gch_ready, m_ready());
        chk("snd0_data_out", snd0_data_out, m_data);
        for (int i = 0; i < 4; i++) if (ack_v[i] && !prev_ack[i]) d_grants.push_back(i);
        prev_ack = ack_v;
        for (int i = 0; i < 4; i++) req_v[i] = ack_v[i] ? 1'b0 : want[i];
        snd0_ack = snd0_req_out;
    endtask

    task automatic run_grants(input logic [3:0] mask, input int n,
                              input int e0, input int e1, input int e2, input int e3, input int e4);
        int exp[5];
        int budget;
        exp = '{e0, e1, e2, e3, e4};
        d_grants.delete(); m_grants.delete();
        want = mask; budget = 0;
        while (d_grants.size() < n && budget < 300) begin cyc(); budget++; end
        want = '0;
        repeat (16) cyc();
        chk("grant_count", d_grants.size(), n);
        chk("model_grant_count", m_grants.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < d_grants.size()) chk("grant_order", d_grants[i], exp[i]);
            if (i < m_grants.size()) chk("model_grant_order", m_grants[i], exp[i]);
        end
    endtask

    initial begin
        bit saw;
        int t;
        data_v[0] = 12'hA01; data_v[1] = 12'h3C7; data_v[2] = 12'h05A; data_v[3] = 12'hF93;
        want = '0; req_v = '0; snd0_ack = 1'b0; prev_ack = '0;
        model_reset();

        rst = 1'b1;
        #1;
        chk("rst_snd0_req", snd0_req_out, 0);
        chk("rst_acks", ack_v, 0);
        chk("rst_ready", gch_ready, 0);
        chk("rst_data", snd0_data_out, 0);
        repeat (3) cyc();
        rst = 1'b0;
        t = 0;
        while (!gch_ready && t < 3) begin cyc(); t++; end
        chk("ready_within_3", gch_ready, 1);

`ifdef HMSG_ARB_FIXED_PRIO_EN
        run_grants(4'b1111, 5, 0, 0, 0, 0, 0);
`else
        run_grants(4'b1111, 5, 0, 1, 2, 3, 0);
`endif

        d_grants.delete(); m_grants.delete();
        want = 4'b0100;
        cyc();
        cyc(); chk("lat_req_c1", snd0_req_out, 0);
        cyc(); chk("lat_req_c2", snd0_req_out, 0);
        cyc(); chk("lat_req_c3", snd0_req_out, 1);
        chk("lat_data", snd0_data_out, 12'h05A);
        cyc(); chk("ack2_c4", ack2, 0);
        cyc(); chk("ack2_c5", ack2, 0);
        cyc(); chk("ack2_c6", ack2, 1);
        want = '0;
        repeat (16) cyc();
        chk("single_grants", d_grants.size(), 1);

`ifdef HMSG_ARB_FIXED_PRIO_EN
        run_grants(4'b1010, 2, 1, 1, 0, 0, 0);
        run_grants(4'b1001, 2, 0, 0, 0, 0, 0);
        run_grants(4'b0101, 2, 0, 0, 0, 0, 0);
`else
        run_grants(4'b1010, 2, 3, 1, 0, 0, 0);
        run_grants(4'b1001, 2, 3, 0, 0, 0, 0);
        run_grants(4'b0101, 2, 2, 0, 0, 0, 0);
`endif

        d_grants.delete(); m_grants.delete();
        saw = 0;
        want = 4'b0010;
        cyc();
        want = '0;
        repeat (10) begin cyc(); saw |= snd0_req_out; end
        chk("glitch_req", saw, 0);
        chk("glitch_grants", d_grants.size(), 0);

        want = 4'b0100;
        t = 0;
        while (!ack2 && t < 40) begin cyc(); t++; end
        chk("midrst_reached_rel", ack2, 1);
        want = '0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_snd0_req", snd0_req_out, 0);
        chk("midrst_ack2", ack2, 0);
        chk("midrst_ready", gch_ready, 0);
        chk("midrst_data", snd0_data_out, 0);
        repeat (3) cyc();
        rst = 1'b0;
        run_grants(4'b1011, 1, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hmsg_rr_arbiter.md
Name: hmsg_rr_arbiter

Overview:
- Four-input round-robin arbiter/merger that shares one outbound message channel among four inbound channels.
- Used in front of a single consumer (e.g. a null sink or a cell port) that several producers must reach.
- All channels use the four-phase req/ack handshake.
- Each inbound request and the outbound ack pass through a REQ_CKS-sample debouncer before any decision is made.

Parameters:
- ASZ, `NS_ADDRESS_SIZE, address field width.
- DSZ, `NS_DATA_SIZE, data field width.
- RSZ, `NS_REDUN_SIZE, redundancy field width.
- REQ_CKS, `NS_REQ_CKS, consecutive samples required for a filtered level change (>=1).
- Derived, not overridable: MSZ = ASZ+DSZ+RSZ, message width.

Ports:
- gch_clk  in  1  single clock, rising edge.
- gch_reset  in  1  asynchronous, active-high reset.
- gch_ready  out  1  high when the block is initialised and all debouncers are primed.
- rcvN_req  in  1  request from producer N (N=0..3).
- rcvN_data  in  MSZ  message from producer N; stable while rcvN_req is high.
- rcvN_ack_out  out  1  ack to producer N.
- snd0_req_out  out  1  request to consumer.
- snd0_data_out  out  MSZ  granted message.
- snd0_ack  in  1  ack from consumer.

Behaviour:
- Reset, asynchronous:
  - All outputs 0: snd0_data_out=0, every ack/req output 0, gch_ready=0.
  - Round-robin pointer = 0, state = INIT.
  - Debouncers are cleared to filtered-low with counters=0.
- Debouncer (one per rcvN_req and one for snd0_ack):
  - Filtered output changes only after the raw input differs from it for REQ_CKS consecutive cycles.
  - It is primed once REQ_CKS cycles have elapsed since reset release.
- gch_ready = rg_rdy AND all five debouncers primed.
- States:
  - INIT: takes one cycle. Sets rg_rdy=1, goes to IDLE.
  - IDLE:
    - Scan filtered requests starting at the pointer p, in order p, p+1, p+2, p+3 mod 4.
    - On the first one high: latch grant index g, latch snd0_data_out<=rcvg_data, set snd0_req_out=1, go to WAIT_ACK.
    - If none is high, stay in IDLE.
  - WAIT_ACK: when filtered snd0_ack=1, set rcvg_ack_out=1 and go to WAIT_REL.
  - WAIT_REL: when filtered rcvg_req=0, clear rcvg_ack_out and snd0_req_out, go to WAIT_DONE.
  - WAIT_DONE: when filtered snd0_ack=0, set pointer <= g+1 mod 4 (3 wraps to 0), go to IDLE.
- Arbitration is only evaluated in IDLE, so at most one grant is active at a time. Non-granted acks stay 0.
- Simultaneous requests are resolved purely by pointer order in the same cycle.
- snd0_data_out holds its value from grant until the next grant; it is never cleared between transfers.
- Latency: with clean inputs in IDLE, snd0_req_out rises REQ_CKS+1 cycles after rcvN_req rises.
- A request that drops before it is granted is simply not granted. No state is kept for it.
- Reset asserted mid-transfer: all outputs drop to 0 immediately (asynchronously). The block restarts at INIT with pointer 0.
- gch_ready low: no grant is issued; IDLE behaves as if no request is high.

Optional Feature:
- Macro: HMSG_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, 0 highest, 3 lowest. The pointer stays 0 and is not updated in WAIT_DONE.
- Undefined: round-robin as specified above.

Test Plan:
- Reset, REQ_CKS=2: all outputs 0 during reset. gch_ready rises within 3 cycles after release.
- Single transfer:
  - Stimulus: rcv2_req=1 with rcv2_data=0x5A, consumer acks.
  - Required: snd0_req_out=1 with data 0x5A after 3 cycles; rcv2_ack_out=1 only after snd0_ack is filtered high.
  - Full four-phase release completes; the pointer becomes 3.
- Fairness: all four requests held high continuously → grant order 0,1,2,3,0; no index granted twice before the others.
- Wrap: pointer=3, requests on 3 and 1 → grant 3 first, then 1; pointer becomes 0, then 2.
- Glitch: rcv1_req pulsed high for 1 cycle with REQ_CKS=2 → no grant, snd0_req_out stays 0.
- Reset mid-transfer: assert gch_reset in WAIT_REL → rcvg_ack_out and snd0_req_out drop to 0 asynchronously; after release, the next grant starts from index 0.
- Fixed-priority build: requests held on 0 and 3 → index 0 is granted every round.
